// File: rtl/mux4_1.sv
// mux4_1: four-input WIDTH-bit multiplexer with a combinational output and a
// registered copy. The registered path also carries the captured select, a
// valid flag, a one-cycle select-change pulse and a saturating count of those
// pulses.
module mux4_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             valid_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sel_chg_cnt
);

  // Next-state values for every register.
  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  logic             valid_d;
  logic             sel_chg_d;
  logic [CNT_W-1:0] sel_chg_cnt_d;

  // An all-ones counter value marks saturation; the count never wraps.
  logic             cnt_sat;
  assign cnt_sat = &sel_chg_cnt;

  // Zero-latency select; an unknown select propagates X in simulation.
  always_comb begin
    case (sel)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = {WIDTH{1'bx}};
    endcase
  end

  // Capture on enable, otherwise hold; the change pulse needs an earlier
  // capture to compare against, so the first capture after reset stays quiet.
  always_comb begin
    out_d         = out_q;
    sel_d         = sel_q;
    valid_d       = valid_q;
    sel_chg_d     = 1'b0;
    sel_chg_cnt_d = sel_chg_cnt;
    if (en) begin
      out_d     = out;
      sel_d     = sel;
      valid_d   = 1'b1;
      sel_chg_d = valid_q && (sel != sel_q);
    end
    // Counter advances on the same edge that registers the pulse.
    if (sel_chg_d && !cnt_sat) begin
      sel_chg_cnt_d = sel_chg_cnt + CNT_W'(1);
    end
  end

  // State registers; reset wins over enable and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      sel_q       <= 2'b00;
      valid_q     <= 1'b0;
      sel_chg     <= 1'b0;
      sel_chg_cnt <= '0;
    end else begin
      out_q       <= out_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      sel_chg     <= sel_chg_d;
      sel_chg_cnt <= sel_chg_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_1.sv
// tb_mux4_1: two instances (4-bit/16-bit counter and 1-bit/2-bit counter)
// share one stimulus stream. Combinational output is checked right after each
// drive; registered outputs are predicted into a queue and checked by an
// independent monitor after each rising edge.
module tb_mux4_1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic [3:0] in0, in1, in2, in3;

  logic [3:0]  out_a, out_q_a;
  logic [1:0]  sel_q_a;
  logic        valid_q_a, sel_chg_a;
  logic [15:0] cnt_a;

  logic [0:0]  out_b, out_q_b;
  logic [1:0]  sel_q_b;
  logic        valid_q_b, sel_chg_b;
  logic [1:0]  cnt_b;

  mux4_1 #(.WIDTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .sel(sel), .en(en),
    .out(out_a), .out_q(out_q_a), .sel_q(sel_q_a),
    .valid_q(valid_q_a), .sel_chg(sel_chg_a), .sel_chg_cnt(cnt_a)
  );

  mux4_1 #(.WIDTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in0(in0[0:0]), .in1(in1[0:0]), .in2(in2[0:0]), .in3(in3[0:0]),
    .sel(sel), .en(en),
    .out(out_b), .out_q(out_q_b), .sel_q(sel_q_b),
    .valid_q(valid_q_b), .sel_chg(sel_chg_b), .sel_chg_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic [1:0] sel;
    logic       valid;
    logic       chg;
    int         cnt_a;
    int         cnt_b;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state, kept as plain integers and flags.
  logic [3:0] m_out;
  int         m_sel;
  bit         m_valid;
  bit         m_chg;
  int         m_cnt_a;
  int         m_cnt_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] pick(input int s);
    logic [3:0] v[4];
    v[0] = in0; v[1] = in1; v[2] = in2; v[3] = in3;
    return v[s];
  endfunction

  // Advance the reference by one clock edge using the currently driven inputs
  // and queue what the registers must show after that edge.
  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_out = 4'h0; m_sel = 0; m_valid = 0; m_chg = 0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (en) begin
      m_chg   = m_valid && (int'(sel) != m_sel);
      m_out   = pick(int'(sel));
      m_sel   = int'(sel);
      m_valid = 1;
      if (m_chg) begin
        m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
      end
    end else begin
      m_chg = 0;
    end
    e.out = m_out; e.sel = m_sel[1:0]; e.valid = m_valid; e.chg = m_chg;
    e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b;
    exp_q.push_back(e);
  endtask

  task automatic check_comb();
    logic [3:0] want;
    want = pick(int'(sel));
    check("out_a", 32'(out_a), 32'(want));
    check("out_b", 32'(out_b), 32'(want[0]));
  endtask

  // Drive one cycle's inputs on the falling edge, check the mux, predict.
  task automatic apply(input logic r, input logic e, input logic [1:0] s,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    rst = r; en = e; sel = s;
    in0 = a; in1 = b; in2 = c; in3 = d;
    #1;
    check_comb();
    model_step();
  endtask

  // Step sel through all four values one time unit apart within a low phase.
  task automatic comb_sweep();
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    in0 = 4'h2; in1 = 4'h5; in2 = 4'hA; in3 = 4'hD;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check_comb();
    end
    model_step();
  endtask

  // Monitor: after every rising edge, compare registered outputs to the
  // oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_q_a",   32'(out_q_a),   32'(e.out));
      check("sel_q_a",   32'(sel_q_a),   32'(e.sel));
      check("valid_q_a", 32'(valid_q_a), 32'(e.valid));
      check("sel_chg_a", 32'(sel_chg_a), 32'(e.chg));
      check("cnt_a",     32'(cnt_a),     32'(e.cnt_a));
      check("out_q_b",   32'(out_q_b),   32'(e.out[0]));
      check("sel_q_b",   32'(sel_q_b),   32'(e.sel));
      check("valid_q_b", 32'(valid_q_b), 32'(e.valid));
      check("sel_chg_b", 32'(sel_chg_b), 32'(e.chg));
      check("cnt_b",     32'(cnt_b),     32'(e.cnt_b));
      $display("edge t=%0t rst=%0b en=%0b sel_q=%0d out_q_a=%0h chg=%0b cnt_a=%0d cnt_b=%0d",
               $time, rst, en, sel_q_a, out_q_a, sel_chg_a, cnt_a, cnt_b);
    end
  end

  initial begin
    int waited;
    rst = 1'b1; en = 1'b0; sel = 2'b00;
    in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0;
    m_out = 4'h0; m_sel = 0; m_valid = 0; m_chg = 0; m_cnt_a = 0; m_cnt_b = 0;

    // Reset (with en high to show rst priority), then combinational sweep.
    apply(1'b1, 1'b1, 2'b01, 4'h2, 4'h5, 4'hA, 4'hD);
    comb_sweep();

    // First capture gives no pulse; a differing second capture pulses.
    apply(1'b0, 1'b1, 2'b01, 4'h2, 4'h5, 4'hA, 4'hD);
    apply(1'b0, 1'b1, 2'b10, 4'h2, 4'h5, 4'hA, 4'hD);

    // Hold while select and data toggle.
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));

    // Same select recaptured with new data: update without pulse.
    apply(1'b0, 1'b1, 2'b10, 4'h2, 4'h5, 4'h7, 4'hD);

    // Alternate 00/11 to drive the 2-bit counter into saturation.
    for (int i = 0; i < 6; i++)
      apply(1'b0, 1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 4'h2, 4'h5, 4'hA, 4'hD);

    // Mid-sequence reset with enable, then capture of a different select.
    apply(1'b1, 1'b1, 2'b11, 4'h2, 4'h5, 4'hA, 4'hD);
    apply(1'b0, 1'b1, 2'b01, 4'h2, 4'h5, 4'hA, 4'hD);
    apply(1'b0, 1'b1, 2'b10, 4'h2, 4'h5, 4'hA, 4'hD);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));

    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
